// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch timekeeping core.
//   state_t          : FSM encoding (IDLE / RUN / PAUSE), 2 bits
//   time_t           : one hours/minutes/seconds/centiseconds snapshot
//   CS_MAX..HR_MAX   : wrap limits of the four counter stages
//   DEFAULT_CLK_FREQ : default system clock frequency in Hz
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] cs;
    } time_t;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 99;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;

endpackage

// File: rtl/sw_mod_counter.sv
// -----------------------------------------------------------------------------
// sw_mod_counter
// Modulo-(MAX+1) counter stage used for each field of the stopwatch cascade.
//   clk   in   system clock
//   rst   in   synchronous active-high reset, zeroes q
//   clr   in   synchronous clear, zeroes q (same effect as rst)
//   en    in   advance by one this cycle
//   q     out  current count, always within 0..MAX
//   carry out  combinational: en && q==MAX (this stage wraps on this edge)
// -----------------------------------------------------------------------------
module sw_mod_counter #(
    parameter int unsigned MAX   = 99,
    parameter int          WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             carry
);

    logic at_max;

    assign at_max = (q == WIDTH'(MAX));
    assign carry  = en && at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_time_counter
// Timekeeping core of the stopwatch: prescaler to a centisecond tick, a
// cascaded cs/s/min/h counter, start/pause/clear FSM, lap freeze and a sticky
// overflow flag.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start_stop   in   1-cycle pulse: start, pause or resume
//   clear        in   1-cycle pulse: zero everything, back to IDLE
//   lap          in   1-cycle pulse: toggle the lap display freeze
//   hours        out  displayed hours 0-99       (registered)
//   minutes      out  displayed minutes 0-59     (registered)
//   seconds      out  displayed seconds 0-59     (registered)
//   centisec     out  displayed centisec 0-99    (registered)
//   running      out  1 while in RUN             (registered)
//   lap_active   out  1 while display is frozen on the lap latch
//   ovf          out  sticky wrap past 99:59:59.99
// Pulse priority: rst > clear > start_stop > lap.
// -----------------------------------------------------------------------------
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int TICK_DIV = CLK_FREQ / 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic [7:0] centisec,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    time_t         live;
    time_t         lap_latch;
    time_t         shown;

    logic cs_carry, sec_carry, min_carry, hr_carry;

    // Prescaler only advances in RUN, so its terminal value alone is not
    // enough: a paused prescaler sitting at PRE_LAST must not tick.
    assign tick = (state == ST_RUN) && (presc == PRE_LAST);

    // Each stage advances only when every lower stage wraps in this cycle.
    sw_mod_counter #(.MAX(CS_MAX), .WIDTH(8)) u_cs (
        .clk(clk), .rst(rst), .clr(clear), .en(tick),
        .q(live.cs), .carry(cs_carry)
    );

    sw_mod_counter #(.MAX(SEC_MAX), .WIDTH(8)) u_sec (
        .clk(clk), .rst(rst), .clr(clear), .en(tick && cs_carry),
        .q(live.sec), .carry(sec_carry)
    );

    sw_mod_counter #(.MAX(MIN_MAX), .WIDTH(8)) u_min (
        .clk(clk), .rst(rst), .clr(clear), .en(tick && sec_carry),
        .q(live.min), .carry(min_carry)
    );

    sw_mod_counter #(.MAX(HR_MAX), .WIDTH(8)) u_hr (
        .clk(clk), .rst(rst), .clr(clear), .en(tick && min_carry),
        .q(live.hr), .carry(hr_carry)
    );

    assign shown = lap_active ? lap_latch : live;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= ST_IDLE;
            presc      <= '0;
            lap_latch  <= '0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            running    <= 1'b0;
            hours      <= 8'd0;
            minutes    <= 8'd0;
            seconds    <= 8'd0;
            centisec   <= 8'd0;
        end else begin
            // Display register: one cycle behind the live count / latch.
            hours    <= shown.hr;
            minutes  <= shown.min;
            seconds  <= shown.sec;
            centisec <= shown.cs;

            if (state == ST_RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
            end

            if (hr_carry) begin
                ovf <= 1'b1;
            end

            if (start_stop) begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    ST_RUN: begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                    ST_PAUSE: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end else if (lap) begin
                // Capture takes the live value before any same-cycle tick.
                if (state == ST_RUN && !lap_active) begin
                    lap_latch  <= live;
                    lap_active <= 1'b1;
                end else if (state != ST_IDLE && lap_active) begin
                    lap_active <= 1'b0;
                end
            end
        end
    end

endmodule
